// File: rtl/core_pkg.sv
// Constants and types shared between the fetch and decode stages of the core.
// Holds the datapath widths, the reset PC default, the PC step and the base opcodes.
package core_pkg;

   localparam int XLEN    = 32;
   localparam int INSTR_W = 32;

   localparam logic [XLEN-1:0]    RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [XLEN-1:0]    PC_STEP          = 32'd4;
   localparam logic [INSTR_W-1:0] NOP              = 32'h0000_0013;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] word;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return pc & ~32'h3;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of {pc, word} entries between instruction memory and decode.
// Clear wins over push and pop so a redirect voids both in the same cycle.
module fetch_fifo
   import core_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           clear,
   input  logic                           push,
   input  logic [XLEN-1:0]                push_pc,
   input  logic [INSTR_W-1:0]             push_word,
   input  logic                           pop,
   output logic [XLEN-1:0]                head_pc,
   output logic [INSTR_W-1:0]             head_word,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           empty,
   output logic                           full
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);

   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_W'(DEPTH));
   assign count     = count_q;
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign head_pc   = empty ? '0 : mem_q[rd_ptr_q].pc;
   assign head_word = empty ? '0 : mem_q[rd_ptr_q].word;

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clear) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = '{pc: push_pc, word: push_word};
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues sequential word requests to instruction memory and
// feeds decode from a small buffer, dropping stale responses after a redirect.
module instruction_fetch
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
);

   localparam int CNT_W = $clog2(BUF_DEPTH + 1);

   logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [CNT_W-1:0] discard_q, discard_d;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W:0]   in_use;
   logic             fifo_empty, fifo_full;
   logic             req_fire, resp_keep, fifo_pop;
   logic [XLEN-1:0]  redirect_target;

   // Every buffer slot is reserved either by an in-flight request or a held word.
   assign in_use          = {1'b0, outstanding_q} + {1'b0, fifo_count};
   assign imem_req_valid  = !reset && !redirect_valid && (in_use < (CNT_W+1)'(BUF_DEPTH));
   assign imem_addr       = fetch_pc_q;
   assign req_fire        = imem_req_valid && imem_req_ready;
   assign resp_keep       = imem_resp_valid && (discard_q == '0);
   assign instr_valid     = !fifo_empty;
   assign fifo_pop        = instr_valid && instr_ready;
   assign redirect_target = align_pc(redirect_pc);

   fetch_fifo #(
      .DEPTH(BUF_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear     (redirect_valid),
      .push      (resp_keep),
      .push_pc   (resp_pc_q),
      .push_word (imem_resp_data),
      .pop       (fifo_pop),
      .head_pc   (instr_pc),
      .head_word (instr),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   // outstanding already includes requests still being dropped, so after a redirect
   // everything in flight except a same-cycle response becomes stale.
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      discard_d     = discard_q;
      outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);
      if (redirect_valid) begin
         fetch_pc_d = redirect_target;
         resp_pc_d  = redirect_target;
         discard_d  = outstanding_q - CNT_W'(imem_resp_valid);
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
         end
         if (imem_resp_valid) begin
            if (discard_q != '0) begin
               discard_d = discard_q - 1'b1;
            end else begin
               resp_pc_d = resp_pc_q + PC_STEP;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(imem_resp_valid && (outstanding_q == '0)));
         assert (!(resp_keep && !redirect_valid && fifo_full));
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed and randomised bench for instruction_fetch with an in-order memory model
// and a stream monitor that checks every consumed instruction's pc and word.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready = 1'b0;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          req_count = 0;
   int          pop_count = 0;
   int          lat_fixed = 1;
   bit          rand_ready = 1'b0;
   bit          rand_lat = 1'b0;
   logic [31:0] pend_addr[$];
   int          pend_due[$];
   logic [31:0] exp_pc = 32'h0;

   instruction_fetch #(
      .RESET_PC  (32'h0000_0000),
      .BUF_DEPTH (2)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_addr       (imem_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .instr_valid     (instr_valid),
      .instr           (instr),
      .instr_pc        (instr_pc),
      .instr_ready     (instr_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkFlag(input string tag, input logic observed, input logic expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic rdv, input logic [31:0] rpc, input logic ird);
      reset          = rst;
      redirect_valid = rdv;
      redirect_pc    = rpc;
      instr_ready    = ird;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitValid(input string tag, input int limit);
      int n = 0;
      while (instr_valid !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
      checkFlag(tag, instr_valid, 1'b1);
   endtask

   // Memory model: records accepted requests and retires presented responses.
   always @(posedge clk) begin
      int lat;
      cyc++;
      if (reset) begin
         pend_addr.delete();
         pend_due.delete();
      end else begin
         if (imem_resp_valid && pend_addr.size() > 0) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
         end
         if (imem_req_valid && imem_req_ready) begin
            lat = rand_lat ? int'($urandom_range(1, 4)) : lat_fixed;
            req_count++;
            pend_addr.push_back(imem_addr);
            pend_due.push_back(cyc + lat);
         end
      end
   end

   always @(negedge clk) begin
      if (reset || pend_addr.size() == 0 || (cyc + 1 < pend_due[0])) begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = 32'h0;
      end else begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mem_word(pend_addr[0]);
      end
      imem_req_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
   end

   // Stream monitor: pcs step by 4 between redirects and words match memory.
   always @(posedge clk) begin
      if (reset) begin
         exp_pc = 32'h0;
      end else if (redirect_valid) begin
         exp_pc = redirect_pc & ~32'h3;
      end else if (instr_valid && instr_ready) begin
         checkOutput("stream_pc", instr_pc, exp_pc);
         checkOutput("stream_word", instr, mem_word(exp_pc));
         exp_pc = exp_pc + 32'd4;
         pop_count++;
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset values and the first sequential fetches.
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      repeat (3) tick();
      checkFlag("rst_req_valid", imem_req_valid, 1'b0);
      checkFlag("rst_instr_valid", instr_valid, 1'b0);
      checkOutput("rst_instr", instr, 32'h0);
      checkOutput("rst_instr_pc", instr_pc, 32'h0);
      checkOutput("rst_addr", imem_addr, 32'h0);

      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      #1;
      checkFlag("seq_first_req", imem_req_valid, 1'b1);
      checkOutput("seq_first_addr", imem_addr, 32'h0);
      tick();
      checkOutput("seq_addr_e1", imem_addr, 32'h4);
      checkFlag("seq_req_e1", imem_req_valid, 1'b1);
      checkFlag("seq_valid_e1", instr_valid, 1'b0);
      tick();
      checkFlag("seq_valid_e2", instr_valid, 1'b1);
      checkOutput("seq_pc_e2", instr_pc, 32'h0);
      checkOutput("seq_word_e2", instr, 32'hDEAD_0000);
      checkFlag("seq_req_e2", imem_req_valid, 1'b0);
      tick();
      checkOutput("seq_pc_e3", instr_pc, 32'h4);
      checkOutput("seq_word_e3", instr, 32'hDEAD_0004);
      checkFlag("seq_req_e3", imem_req_valid, 1'b1);
      checkOutput("seq_addr_e3", imem_addr, 32'h8);
      tick();
      checkFlag("seq_valid_e4", instr_valid, 1'b0);
      checkOutput("seq_addr_e4", imem_addr, 32'hC);

      // Decode stalled: only two requests, head held at pc 0.
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      repeat (2) tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      req_count = 0;
      repeat (10) tick();
      checkOutput("bp_req_count", 32'(req_count), 32'd2);
      checkFlag("bp_valid", instr_valid, 1'b1);
      checkOutput("bp_head_pc", instr_pc, 32'h0);
      checkOutput("bp_head_word", instr, 32'hDEAD_0000);
      checkFlag("bp_req_valid", imem_req_valid, 1'b0);
      pop_count = 0;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      tick();
      checkOutput("bp_resume_pc", instr_pc, 32'h4);
      repeat (12) tick();
      checkFlag("bp_progress", pop_count >= 6, 1'b1);

      // Redirect with two requests in flight at 3-cycle latency.
      lat_fixed = 3;
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      repeat (2) tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      repeat (2) tick();
      applyStimulus(1'b0, 1'b1, 32'h100, 1'b1);
      #1;
      checkFlag("rdr_no_req", imem_req_valid, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      #1;
      checkOutput("rdr_addr", imem_addr, 32'h100);
      checkFlag("rdr_valid_e3", instr_valid, 1'b0);
      tick();
      checkFlag("rdr_valid_e4", instr_valid, 1'b0);
      checkFlag("rdr_req_e4", imem_req_valid, 1'b1);
      checkOutput("rdr_addr_e4", imem_addr, 32'h100);
      waitValid("rdr_wait", 20);
      checkOutput("rdr_pc", instr_pc, 32'h100);
      checkOutput("rdr_word", instr, 32'hDEAD_0100);
      repeat (6) tick();

      // Misaligned redirect target is rounded down to a word.
      applyStimulus(1'b0, 1'b1, 32'h203, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("align_addr", imem_addr, 32'h200);
      waitValid("align_wait", 20);
      checkOutput("align_pc", instr_pc, 32'h200);
      checkOutput("align_word", instr, 32'hDEAD_0200);

      // Redirect on the same edge as a response and a pop.
      lat_fixed = 1;
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      repeat (2) tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      repeat (2) tick();
      checkFlag("same_pre_valid", instr_valid, 1'b1);
      applyStimulus(1'b0, 1'b1, 32'h300, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      #1;
      checkFlag("same_valid_e3", instr_valid, 1'b0);
      checkOutput("same_addr_e3", imem_addr, 32'h300);
      checkFlag("same_req_e3", imem_req_valid, 1'b1);
      tick();
      checkFlag("same_valid_e4", instr_valid, 1'b0);
      tick();
      checkFlag("same_valid_e5", instr_valid, 1'b1);
      checkOutput("same_pc_e5", instr_pc, 32'h300);
      checkOutput("same_word_e5", instr, 32'hDEAD_0300);

      // Random ready, latency, decode stalls and redirects.
      rand_ready = 1'b1;
      rand_lat   = 1'b1;
      pop_count  = 0;
      for (int i = 0; i < 600; i++) begin
         applyStimulus(1'b0, $urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 3) != 0);
         tick();
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      repeat (20) tick();
      checkFlag("rand_progress", pop_count >= 50, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
